// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display scanner.
// Segment bit order is a (bit0) through g (bit6), active-high.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_ZERO  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } scan_phase_t;

endpackage

// File: rtl/scan_slot_timer.sv
// Slot timer for the display scanner.
// cnt counts cycles within a digit slot; idx selects the digit being scanned.
module scan_slot_timer #(
    parameter  int NUM_DIGITS  = 2,
    parameter  int SLOT_CYCLES = 1000,
    localparam int CNT_W       = $clog2(SLOT_CYCLES),
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             slot_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_W'(SLOT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign idx_o      = idx_q;
    assign slot_end_o = slot_end;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes pre-decoded digit patterns onto one segment bus with a
// dead-time blank per slot. SEVEN_SEG_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7*NUM_DIGITS-1:0] digits_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("seven_seg_scanner: NUM_DIGITS must be 2 or more");
    end
    if (SLOT_CYCLES < 2) begin : g_bad_slot
        $error("seven_seg_scanner: SLOT_CYCLES must be 2 or more");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT_CYCLES - 1) begin : g_bad_blank
        $error("seven_seg_scanner: BLANK_CYCLES must be in 1..SLOT_CYCLES-1");
    end

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end;
    logic [7*NUM_DIGITS-1:0] frame_q, frame_d;
    logic [NUM_DIGITS-1:0]   suppress;
    scan_phase_t             phase;

    scan_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_CYCLES(SLOT_CYCLES)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .cnt_o     (cnt),
        .idx_o     (idx),
        .slot_end_o(slot_end)
    );

    assign frame_start = (cnt == '0) && (idx == '0);

    // Capture the whole frame at once so a mid-frame count change cannot tear it.
    assign frame_d = frame_start ? digits_in : frame_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign phase = (int'(cnt) < BLANK_CYCLES) ? PH_BLANK : PH_SHOW;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // A digit is dark only if it and every more-significant digit is a zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        suppress = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero    = all_zero && (frame_q[7*k +: 7] == SEG_ZERO);
            suppress[k] = all_zero;
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        seg_out = SEG_BLANK;
        dig_sel = '0;
        if (phase == PH_SHOW && !suppress[idx]) begin
            dig_sel = NUM_DIGITS'(1) << idx;
            seg_out = frame_q[7*int'(idx) +: 7];
        end
    end

    a_slot_wrap: assert property (@(posedge clk) disable iff (!rst) slot_end |=> (cnt == '0));

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (2 digits, 8-cycle slots, 2 blank).
// Expectations follow SEVEN_SEG_LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic [13:0] digits_in;
    logic [6:0]  seg_out;
    logic [1:0]  dig_sel;
    logic        frame_start;

    int vecCount;
    int missCount;

    seven_seg_scanner #(
        .NUM_DIGITS  (2),
        .SLOT_CYCLES (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] observed();
        return {22'b0, frame_start, dig_sel, seg_out};
    endfunction

    // Expected bus state in a given cycle after reset release, for frame digits d0/d1.
    function automatic logic [31:0] expFor(input int cyc, input logic [6:0] d0, input logic [6:0] d1);
        int         c;
        int         i;
        logic       fs;
        logic [1:0] dsel;
        logic [6:0] seg;
        c    = cyc % 8;
        i    = (cyc / 8) % 2;
        fs   = (c == 0) && (i == 0);
        dsel = 2'b00;
        seg  = 7'h00;
        if (c >= 2) begin
            if (i == 0) begin
                dsel = 2'b01;
                seg  = d0;
            end else begin
                dsel = 2'b10;
                seg  = d1;
            end
        end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (i == 1 && d1 == 7'h3F) begin
            dsel = 2'b00;
            seg  = 7'h00;
        end
`endif
        return {22'b0, fs, dsel, seg};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] digs);
        digits_in = digs;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("in_reset", observed(), 32'h0000_0200);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic checkCycles(input int startCyc, input int n, input logic [6:0] d0, input logic [6:0] d1);
        for (int j = 0; j < n; j++) begin
            checkOutput($sformatf("cyc%0d", startCyc + j), observed(), expFor(startCyc + j, d0, d1));
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int fsCount;
        int fsWide;
        int multiHot;
        int blankViol;
        logic prevFs;

        vecCount  = 0;
        missCount = 0;
        rst       = 1'b0;
        digits_in = '0;

        // Basic scan, then a mid-frame data change that must wait for the next frame.
        applyStimulus({7'h06, 7'h5B});
        resetDut();
        checkCycles(0, 5, 7'h5B, 7'h06);
        applyStimulus({7'h4F, 7'h66});
        checkCycles(5, 11, 7'h5B, 7'h06);
        checkCycles(16, 16, 7'h66, 7'h4F);

        // Asynchronous reset in the middle of a digit-1 show phase.
        checkCycles(32, 12, 7'h66, 7'h4F);
        checkOutput("pre_async_rst", observed(), expFor(44, 7'h66, 7'h4F));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst", observed(), 32'h0000_0200);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkCycles(0, 16, 7'h66, 7'h4F);

        // Long run: frame pulse count and width, one-hot and blank-window sanity.
        resetDut();
        fsCount   = 0;
        fsWide    = 0;
        multiHot  = 0;
        blankViol = 0;
        prevFs    = 1'b0;
        for (int j = 0; j < 1000; j++) begin
            if (frame_start) fsCount++;
            if (frame_start && prevFs) fsWide++;
            if ($countones(dig_sel) > 1) multiHot++;
            if ((j % 8) < 2 && dig_sel != 2'b00) blankViol++;
            prevFs = frame_start;
            @(negedge clk);
            #1;
        end
        checkOutput("frame_pulses", 32'(fsCount), 32'd63);
        checkOutput("frame_pulse_width", 32'(fsWide), 32'd0);
        checkOutput("multi_hot", 32'(multiHot), 32'd0);
        checkOutput("blank_window", 32'(blankViol), 32'd0);

        // Leading zeros: all-zero pattern, then a non-zero upper digit.
        applyStimulus({7'h3F, 7'h3F});
        resetDut();
        checkCycles(0, 16, 7'h3F, 7'h3F);
        applyStimulus({7'h06, 7'h3F});
        checkCycles(16, 16, 7'h3F, 7'h06);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexes NUM_DIGITS pre-decoded 7-segment patterns onto one shared segment bus with one-hot digit enables.
- Sits directly downstream of the counter/decoder pair and feeds the board display pins.
- Snapshots all digit patterns once per frame, so a count change mid-frame never tears the display.
- Inserts a dead-time blank before each digit to suppress ghosting.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; legal values are 2 or more.
- SLOT_CYCLES, 1000, clk cycles per digit slot, blank time included; legal values are 2 or more.
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot; legal range is 1 to SLOT_CYCLES-1.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-low reset; the block is held in reset while rst=0.
- digits_in  in  7*NUM_DIGITS  segment patterns; digit k occupies bits [7k+6:7k]; bit0=a through bit6=g; active-high; digit 0 is least significant.
- seg_out  out  7  shared segment bus, active-high.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high; all zero during blank.
- frame_start  out  1  one-cycle pulse on the first cycle of every frame.

Behaviour:
- State is held in flops only:
  - cnt: width $clog2(SLOT_CYCLES), range 0 to SLOT_CYCLES-1.
  - idx: width $clog2(NUM_DIGITS), range 0 to NUM_DIGITS-1.
  - frame_q: 7*NUM_DIGITS bits.
- Outputs are decoded combinationally from these flops. There is no combinational path from digits_in to any output.
- Reset values: cnt=0, idx=0, frame_q=0. This gives seg_out=0, dig_sel=0 and frame_start=1 while in reset.
- Each edge: cnt increments. When cnt=SLOT_CYCLES-1, cnt wraps to 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
- Slot phases:
  - BLANK, cnt < BLANK_CYCLES: seg_out=0, dig_sel=0.
  - SHOW, cnt >= BLANK_CYCLES: dig_sel=1<<idx, seg_out=frame_q[idx].
- frame_start = (cnt==0 && idx==0).
- Snapshot: frame_q loads digits_in on the rising edge that leaves cnt==0, idx==0. Because BLANK_CYCLES >= 1, the new data is always visible before the first SHOW phase of the frame.
- digits_in changes at any other time take effect only in the next frame.
- The first frame after reset displays the patterns captured on its first edge. The zero reset value of frame_q is never shown.
- Frame length is NUM_DIGITS*SLOT_CYCLES cycles, exactly.
- Reset mid-operation: asserting rst forces the outputs to 0 immediately, without a clock edge. After release, scanning restarts at idx 0, cnt 0.
- Illegal parameters cause an elaboration-time $error.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit k >= 1 is suppressed when frame_q[k] and every higher digit equal SEG_ZERO (7'h3F). A suppressed digit shows dig_sel=0 and seg_out=0 for its whole slot. Digit 0 is never suppressed.
- Not defined: all digits are shown unconditionally. Slot timing is identical in both builds.

Decomposition:
- Package seven_seg_pkg holds:
  - seg_t, a typedef of logic [6:0].
  - SEG_ZERO=7'h3F.
  - SEG_BLANK=7'h00.
  - scan_phase_t, an enum {PH_BLANK, PH_SHOW}.
- One sub-module, scan_slot_timer: the cnt/idx counters with outputs cnt, idx and slot_end. The snapshot register and output decode stay in the top module.

Test Plan (NUM_DIGITS=2, SLOT_CYCLES=8, BLANK_CYCLES=2, cycle 0 = first edge after reset release):
1. digits_in={7'h06,7'h5B} -> frame_start=1 at cycle 0. Cycles 0-1: dig_sel=00, seg=0. Cycles 2-7: dig_sel=01, seg=5B. Cycles 8-9: blank. Cycles 10-15: dig_sel=10, seg=06. frame_start=1 again at cycle 16.
2. digits_in changes to {7'h4F,7'h66} at cycle 5 -> cycles 10-15 still show seg=06. The frame from cycle 16 shows 66 at cycles 18-23 and 4F at cycles 26-31.
3. rst=0 asynchronously at cycle 12.5 -> seg_out and dig_sel are 0 with no clock edge. After release, frame_start=1 and the first SHOW phase is digit 0 at cycle 2.
4. Run 1000 cycles -> exactly 63 frame_start pulses, each one cycle wide. dig_sel is never multi-hot, and is always 0 in cycles with cnt<2.
5. Macro defined, digits_in={7'h3F,7'h3F} -> digit 1 slot is fully blank and digit 0 shows 3F. With {7'h06,7'h3F}, both digits are shown. Macro undefined, {7'h3F,7'h3F} -> both digits are shown.
6. Parameter override BLANK_CYCLES=8 with SLOT_CYCLES=8 -> elaboration $error.
